// File: rtl/mem_arbiter_if.sv
// Shared-RAM bus bundle between the CPU port, the debug/loader port
// and the single-port RAM.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_lock;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_lock,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_addr, d_wdata, d_lock,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin CPU/debug arbiter for the shared program/data RAM,
// with debug burst locking and a bounded CPU starvation limit.
module mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic          busy,
  output logic          owner
);

  typedef enum logic {ARB, LOCKED} st_t;

  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  st_t        fsm, fsm_d;
  logic       last, last_d;
  logic [7:0] cnt, cnt_d;
  logic       rd_pend, rd_pend_d;
  logic       rd_who, rd_who_d;
  logic       gc, gd, forced;

  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;
  logic          we_mux;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm     <= ARB;
      last    <= 1'b1;
      cnt     <= 8'd0;
      rd_pend <= 1'b0;
      rd_who  <= 1'b0;
    end else begin
      fsm     <= fsm_d;
      last    <= last_d;
      cnt     <= cnt_d;
      rd_pend <= rd_pend_d;
      rd_who  <= rd_who_d;
    end
  end

  // grant decision; forced marks the starvation-limit CPU slot
  always_comb begin
    gc     = 1'b0;
    gd     = 1'b0;
    forced = 1'b0;
    if (!reset) begin
      unique case (fsm)
        ARB: begin
          if (bus.c_req && bus.d_req) begin
            gc = last;
            gd = !last;
          end else begin
            gc = bus.c_req;
            gd = bus.d_req;
          end
        end
        LOCKED: begin
          if (bus.c_req && cnt == MAXB) begin
            gc     = 1'b1;
            forced = 1'b1;
          end else if (bus.d_req) begin
            gd = 1'b1;
          end else if (bus.c_req) begin
            gc = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    fsm_d     = fsm;
    cnt_d     = cnt;
    last_d    = last;
    rd_pend_d = (gc && !bus.c_we) || (gd && !bus.d_we);
    rd_who_d  = gd;
    if (gc) last_d = 1'b0;
    if (gd) last_d = 1'b1;
    unique case (fsm)
      ARB: begin
        if (gd && bus.d_lock) begin
          fsm_d = LOCKED;
          cnt_d = 8'd1;
        end
      end
      LOCKED: begin
        if (!bus.d_lock) begin
          fsm_d = ARB;
          cnt_d = 8'd0;
        end else if (forced) begin
          cnt_d = 8'd0;
        end else if (gd) begin
          cnt_d = (cnt >= MAXB) ? MAXB : cnt + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    if (gc) begin
      addr_mux  = bus.c_addr;
      wdata_mux = bus.c_wdata;
      we_mux    = bus.c_we;
    end else if (gd) begin
      addr_mux  = bus.d_addr;
      wdata_mux = bus.d_wdata;
      we_mux    = bus.d_we;
    end
  end

  assign bus.c_gnt    = gc;
  assign bus.d_gnt    = gd;
  assign bus.m_en     = gc | gd;
  assign bus.m_we     = we_mux;
  assign bus.m_addr   = addr_mux;
  assign bus.m_wdata  = wdata_mux;
  assign bus.c_rvalid = rd_pend && !rd_who && !reset;
  assign bus.d_rvalid = rd_pend && rd_who && !reset;
  assign bus.c_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;
  assign busy         = (fsm == LOCKED);
  assign owner        = last;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed grant plan, RAM model,
// read-return queue checked against a bench-side reference memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic busy, owner;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(
    .AW(16), .DW(16), .MAX_BURST(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .owner(owner)
  );

  logic [15:0] ram     [0:255];
  logic [15:0] ref_mem [0:255];

  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) ram[bus.m_addr[7:0]] <= bus.m_wdata;
      else bus.m_rdata <= ram[bus.m_addr[7:0]];
    end
  end

  typedef struct {
    logic        who;
    logic [15:0] data;
    int          due;
  } rd_t;

  rd_t q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;
  logic rst_seen = 1'b0;
  logic exp_owner = 1'b1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h",
                  tag, cyc, got, exp);
  endtask

  localparam int GN = 0;
  localparam int GC = 1;
  localparam int GD = 2;

  task automatic step(input logic cr, input logic cw,
                      input logic [15:0] ca, input logic [15:0] cd,
                      input logic dr, input logic dw,
                      input logic [15:0] da, input logic [15:0] dd,
                      input logic dl, input int eg, input logic eb);
    rd_t r;
    logic ecv, edv;
    logic [15:0] ed;
    bus.c_req = cr; bus.c_we = cw;
    bus.c_addr = ca; bus.c_wdata = cd;
    bus.d_req = dr; bus.d_we = dw;
    bus.d_addr = da; bus.d_wdata = dd;
    bus.d_lock = dl;
    #2;
    chk("c_gnt", 32'(bus.c_gnt), 32'(eg == GC));
    chk("d_gnt", 32'(bus.d_gnt), 32'(eg == GD));
    chk("m_en", 32'(bus.m_en), 32'(eg != GN));
    chk("m_addr", 32'(bus.m_addr),
        (eg == GC) ? 32'(ca) : (eg == GD) ? 32'(da) : 32'd0);
    chk("m_we", 32'(bus.m_we),
        (eg == GC) ? 32'(cw) : (eg == GD) ? 32'(dw) : 32'd0);
    if (rst_seen && !reset) begin
      chk("busy", 32'(busy), 32'(eb));
      chk("owner", 32'(owner), 32'(exp_owner));
    end
    ecv = 1'b0; edv = 1'b0; ed = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      if (!reset) begin
        ecv = !r.who; edv = r.who; ed = r.data;
      end
    end
    chk("c_rvalid", 32'(bus.c_rvalid), 32'(ecv));
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(edv));
    if (ecv) chk("c_rdata", 32'(bus.c_rdata), 32'(ed));
    if (edv) chk("d_rdata", 32'(bus.d_rdata), 32'(ed));
    if (eg == GC) begin
      if (!cw) q.push_back('{1'b0, ref_mem[ca[7:0]], cyc + 1});
      else ref_mem[ca[7:0]] = cd;
      exp_owner = 1'b0;
    end
    if (eg == GD) begin
      if (!dw) q.push_back('{1'b1, ref_mem[da[7:0]], cyc + 1});
      else ref_mem[da[7:0]] = dd;
      exp_owner = 1'b1;
    end
    if (reset) exp_owner = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) rst_seen = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 16'(i) ^ 16'hA5A5;
      ref_mem[i] = 16'(i) ^ 16'hA5A5;
    end
    ram[16'h10]     = 16'hBEEF;
    ref_mem[16'h10] = 16'hBEEF;
    bus.m_rdata = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // reset with both requesting
    step(1, 0, 16'h10, 0, 1, 0, 16'h11, 0, 0, GN, 0);
    step(1, 0, 16'h10, 0, 1, 0, 16'h11, 0, 0, GN, 0);
    reset = 1'b0;

    // contention in ARB: C, D, C, D
    step(1, 0, 16'h10, 0, 1, 0, 16'h11, 0, 0, GC, 0);
    step(1, 0, 16'h12, 0, 1, 0, 16'h11, 0, 0, GD, 0);
    step(1, 0, 16'h12, 0, 1, 0, 16'h13, 0, 0, GC, 0);
    step(1, 0, 16'h14, 0, 1, 0, 16'h13, 0, 0, GD, 0);

    // read steering
    step(1, 0, 16'h10, 0, 0, 0, 0, 0, 0, GC, 0);
    step(0, 0, 0, 0, 1, 1, 16'h20, 16'h1234, 0, GD, 0);
    step(0, 0, 0, 0, 1, 0, 16'h20, 0, 0, GD, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, GN, 0);

    // lock while CPU wins the tie: no LOCKED entry
    step(1, 0, 16'h10, 0, 1, 1, 16'h40, 16'h0007, 1, GC, 0);

    // lock burst: 8 D then 1 C, repeated
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 16'h10, 0,
           1, 1, 16'(16'h41 + i), 16'(i * 3 + 7), 1,
           ((i % 9) == 8) ? GC : GD, (i > 0));
    end

    // lock exit mid-burst: LOCKED rules this cycle, ARB after
    step(1, 0, 16'h10, 0, 1, 0, 16'h43, 0, 0, GD, 1);
    step(1, 0, 16'h10, 0, 1, 0, 16'h44, 0, 0, GC, 0);
    step(1, 0, 16'h10, 0, 1, 0, 16'h44, 0, 0, GD, 0);

    // reset mid-read
    step(0, 0, 0, 0, 1, 0, 16'h45, 0, 0, GD, 0);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, GN, 0);
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, GN, 0);
    step(1, 0, 16'h20, 0, 1, 0, 16'h21, 0, 0, GC, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, GN, 0);

    if (q.size() != 0) chk("sb_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port program/data RAM between the CPU memory interface (fetch, LD, STO, LDI) and the debug/program-loader port. Grants are issued combinationally in the request cycle, fairness is round-robin, and the loader may lock the bus for bursts with a bounded CPU-starvation limit. Read data returns one cycle after grant and is steered to the requester that issued the read.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width
- MAX_BURST, 8, consecutive debug grants allowed in LOCKED before a pending CPU request is forced through (range 1..255)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset synchronous active-high
- c_req  in  1  CPU access request; held with c_we/c_addr/c_wdata stable until c_gnt
- c_we  in  1  CPU write enable (1 = write, 0 = read)
- c_addr  in  AW  CPU address
- c_wdata  in  DW  CPU write data
- c_gnt  out  1  CPU access issued to RAM this cycle
- c_rvalid  out  1  CPU read data valid on c_rdata
- c_rdata  out  DW  CPU read data
- d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  debug-port equivalents of the c_* inputs
- d_lock  in  1  debug requests burst ownership
- d_gnt, d_rvalid  out  1  debug grant / read valid
- d_rdata  out  DW  debug read data
- m_en  out  1  RAM access enable
- m_we  out  1  RAM write enable
- m_addr  out  AW  RAM address
- m_wdata  out  DW  RAM write data
- m_rdata  in  DW  RAM read data, valid the cycle after a read access
- busy  out  1  1 while in LOCKED (status LED)
- owner  out  1  last-granted requester: 0 = CPU, 1 = debug (status LED)

## Operation
- Registered state: fsm (ARB, LOCKED), last (0 = C, 1 = D), burst_cnt (8 bits), rd_pend, rd_who.
- Grant logic is combinational from the current requests and registered state. At most one of c_gnt/d_gnt is 1. m_en = c_gnt | d_gnt. m_we/m_addr/m_wdata are muxed from the granted port and are all 0 when there is no grant.
- ARB:
  - Only one requester: grant it.
  - Both requesting: grant the requester opposite to last.
  - Debug granted with d_lock=1: go to LOCKED, burst_cnt←1.
- LOCKED, priority order:
  - c_req and burst_cnt==MAX_BURST: grant C, burst_cnt←0.
  - Else d_req: grant D, burst_cnt←min(burst_cnt+1, MAX_BURST).
  - Else c_req: grant C, burst_cnt unchanged.
- Exit: LOCKED→ARB at any edge where d_lock=0. burst_cnt←0. The grant in that same cycle still follows LOCKED rules.
- d_lock in ARB without a debug grant has no effect.
- last updates on every grant to the granted port. owner = last.
- Read return: on a grant with we=0, rd_pend←1 and rd_who←granted port; otherwise rd_pend←0. c_rvalid = rd_pend & (rd_who==C). d_rvalid = rd_pend & (rd_who==D). c_rdata = d_rdata = m_rdata.
- A requester that sees gnt at a rising edge either drops req or presents its next access. Back-to-back grants to the same port are legal.

## Timing
- Grant latency 0 cycles when uncontested. A contested requester waits at most 1 cycle in ARB and at most MAX_BURST grants in LOCKED.
- Read data arrives 1 cycle after gnt. Write completes at the gnt edge.
- Reset (synchronous):
  - While reset=1, all grants, m_en, m_we, rvalids are forced to 0 and m_addr/m_wdata are 0.
  - Registers load fsm=ARB, last=1 (CPU wins the first tie), burst_cnt=0, rd_pend=0.
  - Outputs after reset: busy=0, owner=1.
  - A read granted in the cycle before reset produces no rvalid.
- Simultaneous d_lock fall and c_req in LOCKED: that cycle's arbitration uses LOCKED rules; ARB applies from the next cycle.

## Test plan
- Reset: hold reset 2 cycles with c_req=d_req=1 -> no gnt/m_en. First cycle after reset -> c_gnt=1, owner←0.
- Contention in ARB: c_req=d_req=1 continuously for 4 cycles, no lock -> grants alternate C,D,C,D. m_addr follows the granted port.
- Read steering: CPU read at 0x0010 (RAM holds 0xBEEF), debug write 0x1234 to 0x0020 next cycle -> c_rvalid=1 with c_rdata=0xBEEF one cycle after c_gnt, d_rvalid=0. A later debug read of 0x0020 returns 0x1234 with d_rvalid only.
- Lock burst with MAX_BURST=8: d_lock=1, d_req=1, c_req=1 for 20 cycles -> busy=1, eight D grants then one C grant, repeated. c_gnt never absent for more than 8 consecutive cycles.
- Lock exit: drop d_lock mid-burst -> busy=0 next cycle and round-robin resumes. Asserting d_lock while CPU holds the grant -> no LOCKED entry.
- Reset mid-read: debug read granted, reset asserted next cycle -> d_rvalid=0, fsm=ARB, burst_cnt=0.
